// File: rtl/conv_pkg.sv
// Shared types and constants for the conv MAC arbiter slice.
// Optional build macro used by the top: CONV_ZERO_SKIP_EN.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        CAPTURE,
        RESP
    } state_t;

    localparam int DEF_WIDTH = 6;
    localparam int DEF_SUM_W = 4;

    // Bits needed to hold 0..width (minimum legal SUM_W, also the bit counter width)
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/conv_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
module conv_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                       gnt_any
);
    localparam int ID_W = $clog2(NUM_REQ);

    // Scan from farthest to nearest offset so the nearest valid one wins last
    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_idx  = idx[ID_W-1:0];
                gnt_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_mac_arbiter.sv
// Round-robin controller sharing one bit-serial AND/popcount datapath.
// Build macro CONV_ZERO_SKIP_EN: jobs with an all-zero operand skip the
// datapath and respond with sum 0 straight from the grant.
module conv_mac_arbiter
    import conv_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SUM_W   = DEF_SUM_W
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [WIDTH-1:0]           dp_a,
    output logic [WIDTH-1:0]           dp_b,
    output logic                       dp_load,
    output logic                       dp_shift_en,
    output logic                       dp_acc_sel,
    output logic                       dp_acc_en,
    input  logic [SUM_W-1:0]           dp_sum,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [SUM_W-1:0]           rsp_sum,
    input  logic                       rsp_ready,
    output logic                       busy
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_w(WIDTH);

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [CNT_W-1:0]  cnt;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic [WIDTH-1:0]  win_a;
    logic [WIDTH-1:0]  win_b;

    conv_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_valid (req_valid),
        .ptr       (ptr),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_any   (gnt_any)
    );

    // Grant is only offered while idle; winner operands selected for latching
    always_comb begin
        req_ready = (state == IDLE) ? gnt : '0;
        win_a     = req_a[gnt_idx*WIDTH +: WIDTH];
        win_b     = req_b[gnt_idx*WIDTH +: WIDTH];
    end

    // Job FSM; datapath enables are registered alongside the next state
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            dp_a        <= '0;
            dp_b        <= '0;
            dp_load     <= 1'b0;
            dp_shift_en <= 1'b0;
            dp_acc_sel  <= 1'b0;
            dp_acc_en   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_sum     <= '0;
            busy        <= 1'b0;
        end else begin
            dp_load     <= 1'b0;
            dp_shift_en <= 1'b0;
            dp_acc_sel  <= 1'b0;
            dp_acc_en   <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        dp_a   <= win_a;
                        dp_b   <= win_b;
                        rsp_id <= gnt_idx;
                        ptr    <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                        busy   <= 1'b1;
`ifdef CONV_ZERO_SKIP_EN
                        if (win_a == '0 || win_b == '0) begin
                            rsp_sum   <= '0;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else
`endif
                        begin
                            dp_load   <= 1'b1;
                            dp_acc_en <= 1'b1;
                            state     <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    cnt         <= '0;
                    dp_shift_en <= 1'b1;
                    dp_acc_sel  <= 1'b1;
                    dp_acc_en   <= 1'b1;
                    state       <= SHIFT;
                end
                SHIFT: begin
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= CAPTURE;
                    end else begin
                        cnt         <= cnt + 1'b1;
                        dp_shift_en <= 1'b1;
                        dp_acc_sel  <= 1'b1;
                        dp_acc_en   <= 1'b1;
                    end
                end
                CAPTURE: begin
                    rsp_sum   <= dp_sum;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mac_arbiter.sv
// Self-checking bench for conv_mac_arbiter (NUM_REQ=2, WIDTH=6) with a
// behavioural datapath model and a round-robin reference model.
module tb_conv_mac_arbiter;
    localparam int NR = 2;
    localparam int W  = 6;
    localparam int SW = 4;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [NR-1:0]   req_valid;
    logic [NR*W-1:0] req_a, req_b;
    logic [NR-1:0]   req_ready;
    logic [W-1:0]    dp_a, dp_b;
    logic            dp_load, dp_shift_en, dp_acc_sel, dp_acc_en;
    logic [SW-1:0]   dp_sum;
    logic            rsp_valid;
    logic            rsp_id;
    logic [SW-1:0]   rsp_sum;
    logic            rsp_ready;
    logic            busy;

    conv_mac_arbiter #(.NUM_REQ(NR), .WIDTH(W), .SUM_W(SW)) dut (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .dp_a(dp_a), .dp_b(dp_b), .dp_load(dp_load),
        .dp_shift_en(dp_shift_en), .dp_acc_sel(dp_acc_sel), .dp_acc_en(dp_acc_en),
        .dp_sum(dp_sum), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    always #5 clock = ~clock;

    // Behavioural bit-serial datapath: shift registers plus accumulator
    logic [W-1:0]  sa = '0, sb = '0;
    logic [SW-1:0] acc = '0;
    assign dp_sum = acc;
    always @(posedge clock) begin
        if (dp_acc_en)
            acc <= (dp_acc_sel ? acc : '0) + ((dp_shift_en && sa[0] && sb[0]) ? SW'(1) : SW'(0));
        if (dp_load) begin
            sa <= dp_a;
            sb <= dp_b;
        end else if (dp_shift_en) begin
            sa <= sa >> 1;
            sb <= sb >> 1;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;
    int mptr   = 0;   // reference round-robin pointer

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int model_pick(input logic [NR-1:0] vld);
        for (int k = 0; k < NR; k++)
            if (vld[(mptr + k) % NR]) return (mptr + k) % NR;
        return -1;
    endfunction

    // One full job: entered at posedge+1 with DUT idle, returns at posedge+1 after handshake
    task automatic do_job(input logic [1:0] vld, input logic [W-1:0] a0, b0, a1, b1,
                          input int hold, input int exp_id, input int exp_sum);
        logic [W-1:0] aw, bw;
        int lat, c;
        aw = exp_id ? a1 : a0;
        bw = exp_id ? b1 : b0;
        lat = W + 3;
`ifdef CONV_ZERO_SKIP_EN
        if (aw == '0 || bw == '0) lat = 1;
`endif
        req_valid = vld;
        req_a = {a1, a0};
        req_b = {b1, b0};
        rsp_ready = (hold == 0);
        @(negedge clock);
        chk("grant_onehot", req_ready, 32'(2'b01 << exp_id));
        chk("idle_busy", busy, 0);
        @(posedge clock); #1;
        chk("latched_a", dp_a, aw);
        chk("latched_b", dp_b, bw);
        for (c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (rsp_valid) break;
            chk("dp_load", dp_load, 32'(c == 1));
            chk("dp_shift_en", dp_shift_en, 32'(c >= 2 && c <= W + 1));
            chk("dp_acc_en", dp_acc_en, 32'(c >= 1 && c <= W + 1));
            chk("dp_acc_sel", dp_acc_sel, 32'(c >= 2 && c <= W + 1));
            chk("job_ready", req_ready, 0);
            chk("job_busy", busy, 1);
        end
        if (c > 20) begin
            chk("rsp_timeout", 0, 1);
            return;
        end
        chk("rsp_latency", c, lat);
        chk("rsp_id", rsp_id, exp_id);
        chk("rsp_sum", rsp_sum, exp_sum);
        chk("rsp_dp_idle", {dp_load, dp_shift_en, dp_acc_en, dp_acc_sel}, 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clock);
            @(negedge clock);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_id", rsp_id, exp_id);
            chk("hold_sum", rsp_sum, exp_sum);
            chk("hold_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        chk("done_valid", rsp_valid, 0);
        chk("done_busy", busy, 0);
        mptr = (exp_id + 1) % NR;
    endtask

    typedef struct {
        logic [1:0]   vld;
        logic [W-1:0] a0, b0, a1, b1;
        int           hold;
        int           exp_id;
        int           exp_sum;
    } vec_t;

    vec_t vecs[7];

    initial begin
        bit seen;
        logic [1:0] rv;
        logic [W-1:0] ra0, rb0, ra1, rb1;
        int rid;

        // Table (pointer starts at 0 after reset); ids/sums derived by hand
        vecs[0] = '{2'b10, 6'b000000, 6'b000000, 6'b111111, 6'b111111, 0, 1, 6};
        vecs[1] = '{2'b01, 6'b111111, 6'b101010, 6'b000000, 6'b000000, 0, 0, 3};
        vecs[2] = '{2'b01, 6'b000000, 6'b111111, 6'b000000, 6'b000000, 0, 0, 0};
        vecs[3] = '{2'b11, 6'b110011, 6'b010111, 6'b101100, 6'b111001, 5, 1, 2};
        vecs[4] = '{2'b11, 6'b110011, 6'b010111, 6'b101100, 6'b111001, 0, 0, 3};
        vecs[5] = '{2'b11, 6'b110011, 6'b010111, 6'b101100, 6'b111001, 0, 1, 2};
        vecs[6] = '{2'b10, 6'b000000, 6'b000000, 6'b111111, 6'b000000, 1, 1, 0};

        reset_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_dp_ctl", {dp_load, dp_shift_en, dp_acc_en, dp_acc_sel}, 0);
        chk("rst_dp_a", dp_a, 0);
        chk("rst_dp_b", dp_b, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        reset_n = 1'b1;
        @(posedge clock); #1;
        chk("idle_no_ready", req_ready, 0);

        foreach (vecs[i])
            do_job(vecs[i].vld, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1,
                   vecs[i].hold, vecs[i].exp_id, vecs[i].exp_sum);

        // Reset in the third SHIFT cycle discards the job and the pointer
        req_a = {6'b0, 6'b110110}; req_b = {6'b0, 6'b011111}; req_valid = 2'b01; rsp_ready = 1'b1;
        @(negedge clock);
        chk("rst_seq_grant", req_ready, 2'b01);
        @(posedge clock); #1;
        req_valid = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_seq_shifting", dp_shift_en, 1);
        reset_n = 1'b0;
        @(posedge clock); #1;
        chk("rst_seq_busy", busy, 0);
        chk("rst_seq_ctl", {dp_load, dp_shift_en, dp_acc_en, dp_acc_sel, rsp_valid}, 0);
        chk("rst_seq_dp_a", dp_a, 0);
        chk("rst_seq_dp_b", dp_b, 0);
        chk("rst_seq_sum", rsp_sum, 0);
        chk("rst_seq_id", rsp_id, 0);
        reset_n = 1'b1;
        mptr = 0;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clock);
            seen |= rsp_valid;
        end
        chk("rst_seq_no_rsp", seen, 0);
        @(posedge clock); #1;
        do_job(2'b11, 6'b111000, 6'b101000, 6'b111111, 6'b111111, 0, 0, 2);

        // Randomized jobs against the reference model
        for (int n = 0; n < 40; n++) begin
            rv  = 2'($urandom_range(1, 3));
            ra0 = 6'($urandom); rb0 = 6'($urandom);
            ra1 = 6'($urandom); rb1 = 6'($urandom);
            if ($urandom_range(0, 7) == 0) ra0 = '0;
            if ($urandom_range(0, 7) == 0) rb1 = '0;
            rid = model_pick(rv);
            do_job(rv, ra0, rb0, ra1, rb1, $urandom_range(0, 2), rid,
                   rid ? $countones(ra1 & rb1) : $countones(ra0 & rb0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/conv_mac_arbiter.md
Name: conv_mac_arbiter

Overview:
Controller and round-robin arbiter that shares one bit-serial AND/popcount dot-product datapath between NUM_REQ requesters. It grants one request at a time, latches the operand pair and drives the datapath's load, shift and accumulate enables. It then captures the accumulator result and returns it with the requester ID over a valid/ready response channel. It sits between the convolution front-end request sources and the shared MAC datapath.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
WIDTH, 6, operand vector length in bits
SUM_W, 4, result width; must be at least clog2(WIDTH+1)

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous reset, active-low
req_valid  in  NUM_REQ  per-requester request valid
req_a  in  NUM_REQ*WIDTH  operand A, slice i belongs to requester i
req_b  in  NUM_REQ*WIDTH  operand B, slice i belongs to requester i
req_ready  out  NUM_REQ  one-hot grant/accept pulse
dp_a  out  WIDTH  latched operand A to datapath
dp_b  out  WIDTH  latched operand B to datapath
dp_load  out  1  datapath shift-register load
dp_shift_en  out  1  datapath shift enable
dp_acc_sel  out  1  0 = accumulator adds to zero (clear), 1 = accumulator adds to old sum
dp_acc_en  out  1  accumulator register enable
dp_sum  in  SUM_W  datapath accumulator value
rsp_valid  out  1  result valid
rsp_id  out  clog2(NUM_REQ)  requester that owns the result
rsp_sum  out  SUM_W  dot-product result
rsp_ready  in  1  result consumer ready
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - State goes to IDLE; round-robin pointer goes to 0.
  - All outputs go to 0, including dp_a, dp_b, rsp_id and rsp_sum.
  - An in-flight job is discarded and produces no response.
- States: IDLE, LOAD, SHIFT, CAPTURE, RESP.
- IDLE:
  - If any req_valid bit is set, pick the first set bit at or after the pointer, wrapping around.
  - In the same cycle, req_ready[winner]=1; this is combinational from req_valid and state.
  - At the edge: latch req_a/req_b slices into dp_a/dp_b and the winner index into rsp_id; pointer becomes winner+1 mod NUM_REQ; go to LOAD.
  - With no valid request, stay in IDLE.
- LOAD (1 cycle): dp_load=1, dp_acc_sel=0, dp_acc_en=1, so the accumulator clears. Go to SHIFT with the bit counter at 0.
- SHIFT (exactly WIDTH cycles): dp_shift_en=1, dp_acc_sel=1, dp_acc_en=1. The counter increments each cycle; leave for CAPTURE when it reaches WIDTH-1.
- CAPTURE (1 cycle): all dp enables are 0. Register dp_sum into rsp_sum, then go to RESP.
- RESP:
  - rsp_valid=1, with rsp_id and rsp_sum held stable until rsp_ready=1.
  - Return to IDLE on the handshake edge. The next grant occurs no earlier than the following cycle.
- Handshake rules:
  - req_ready is asserted only in IDLE.
  - A requester holds valid and operands until it sees req_ready; deasserting valid before grant withdraws the request.
  - Requesters not granted see no req_ready.
- Latency: grant in cycle 0, LOAD in cycle 1, SHIFT in cycles 2..WIDTH+1, CAPTURE in cycle WIDTH+2, rsp_valid from cycle WIDTH+3 (cycle 9 for WIDTH=6).
- Outside the states listed above, dp_load, dp_shift_en, dp_acc_sel and dp_acc_en are 0.
- Arithmetic: the result is popcount(a & b), range 0..WIDTH. It is never truncated while SUM_W >= clog2(WIDTH+1).
- Illegal state encoding: go to IDLE with all outputs deasserted.

Optional Feature:
CONV_ZERO_SKIP_EN
- Defined: at grant, if the winning req_a or req_b slice is all zero, go directly IDLE to RESP with rsp_sum=0.
  - No dp_load, dp_shift_en or dp_acc_en is asserted.
  - rsp_valid appears in cycle 1.
- Undefined: every job runs the full LOAD/SHIFT/CAPTURE sequence.

Decomposition:
- Package conv_pkg holds:
  - state enum typedef (IDLE, LOAD, SHIFT, CAPTURE, RESP);
  - default WIDTH/SUM_W constants;
  - function returning clog2(WIDTH+1).
- One sub-module, conv_rr_arbiter: combinational round-robin pick from req_valid and pointer, producing the one-hot grant and the grant index. Pointer storage stays in the top-level.

Test Plan:
The bench includes a behavioural datapath model. All scenarios use NUM_REQ=2, WIDTH=6.
1. req0 only, a=111111, b=101010:
   - req_ready=01 in cycle 0, dp_load in cycle 1, dp_shift_en in cycles 2-7.
   - rsp_valid in cycle 9 with rsp_id=0, rsp_sum=3.
2. req0 and req1 held valid continuously after reset with rsp_ready=1: grants alternate 0,1,0,1; no grant ever overlaps busy.
3. rsp_ready held low 5 cycles in RESP: rsp_valid, rsp_id and rsp_sum stay stable and req_ready stays 00; completion occurs on the cycle rsp_ready rises.
4. reset_n=0 in the third SHIFT cycle: the next cycle shows all outputs 0 and busy=0, no response is ever issued, and the next grant goes to req0.
5. a=000000, b=111111:
   - With CONV_ZERO_SKIP_EN: rsp_valid in cycle 1 with rsp_sum=0 and no dp_load.
   - Without it: full 9-cycle sequence with rsp_sum=0.
6. a=b=111111 from req1: rsp_id=1, rsp_sum=6; req1 is granted while req0 is idle even though the pointer is 0.
